// File: rtl/dump_sequencer.sv
// dump_sequencer: captures a snapshot and streams it to the UART as header, data LSB-first, XOR checksum
module dump_sequencer #(
    parameter int         NBYTES = 16,
    parameter logic [7:0] HEADER = 8'hA5
) (
    input  logic                  top_clk,
    input  logic                  rst,
    input  logic                  dump_req,
    input  logic [NBYTES*8-1:0]   snapshot,
    input  logic                  tx_done_tick,
    output logic                  tx_start,
    output logic [7:0]            tx_bus,
    output logic                  busy,
    output logic                  done
);
    localparam int IW = $clog2(NBYTES + 2);
    localparam logic [IW-1:0] LAST = IW'(NBYTES + 1);

    typedef enum logic [1:0] {IDLE, SEND, WAIT, FIN} state_t;

    state_t                state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [7:0]            csum_q, csum_d;
    logic [NBYTES*8-1:0]   shadow_q, shadow_d;
    logic                  tx_start_q, tx_start_d;
    logic [7:0]            tx_bus_q, tx_bus_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [IW-1:0]         didx;
    logic [NBYTES*8-1:0]   shifted;

    assign didx     = idx_q - IW'(1);
    assign shifted  = shadow_q >> {didx, 3'b000};
    assign tx_start = tx_start_q;
    assign tx_bus   = tx_bus_q;
    assign busy     = busy_q;
    assign done     = done_q;

    // The header is ready at acceptance, so IDLE loads it directly and SEND is the prep cycle for later bytes
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        csum_d     = csum_q;
        shadow_d   = shadow_q;
        tx_start_d = 1'b0;
        tx_bus_d   = tx_bus_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: if (dump_req) begin
                shadow_d   = snapshot;
                idx_d      = '0;
                csum_d     = '0;
                tx_start_d = 1'b1;
                tx_bus_d   = HEADER;
                busy_d     = 1'b1;
                state_d    = WAIT;
            end
            SEND: begin
                tx_start_d = 1'b1;
                tx_bus_d   = (idx_q == LAST) ? csum_q : shifted[7:0];
                state_d    = WAIT;
            end
            WAIT: if (tx_done_tick && !tx_start_q) begin
                csum_d = (idx_q != '0 && idx_q != LAST) ? csum_q ^ tx_bus_q : csum_q;
                if (idx_q == LAST) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = FIN;
                end else begin
                    idx_d   = idx_q + IW'(1);
                    state_d = SEND;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge top_clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            csum_q     <= '0;
            shadow_q   <= '0;
            tx_start_q <= 1'b0;
            tx_bus_q   <= 8'h00;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            csum_q     <= csum_d;
            shadow_q   <= shadow_d;
            tx_start_q <= tx_start_d;
            tx_bus_q   <= tx_bus_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end
endmodule

// File: tb/tb_dump_sequencer.sv
// tb_dump_sequencer: randomized frame driver checked against a byte-list model of the frame format
module tb_dump_sequencer;
    localparam int NB = 4;
    localparam logic [7:0] HDR = 8'hA5;

    logic            top_clk = 1'b0;
    logic            rst = 1'b0;
    logic            dump_req = 1'b0;
    logic [NB*8-1:0] snapshot = '0;
    logic            tx_done_tick = 1'b0;
    logic            tx_start;
    logic [7:0]      tx_bus;
    logic            busy;
    logic            done;

    int n_cmp = 0;
    int n_err = 0;
    int starts = 0;
    int dones = 0;

    dump_sequencer #(.NBYTES(NB), .HEADER(HDR)) dut (
        .top_clk(top_clk), .rst(rst), .dump_req(dump_req), .snapshot(snapshot),
        .tx_done_tick(tx_done_tick), .tx_start(tx_start), .tx_bus(tx_bus),
        .busy(busy), .done(done)
    );

    always #5 top_clk = ~top_clk;

    always @(posedge top_clk) begin
        if (tx_start) starts++;
        if (done) dones++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Frame = header, data bytes LSB-first, XOR of the data bytes
    task automatic build(input logic [NB*8-1:0] snap, output logic [7:0] exp [NB+2]);
        logic [7:0] x;
        x = 8'h00;
        exp[0] = HDR;
        for (int i = 0; i < NB; i++) begin
            exp[i+1] = snap[8*i +: 8];
            x ^= snap[8*i +: 8];
        end
        exp[NB+1] = x;
    endtask

    task automatic frame(input logic [NB*8-1:0] snap, input int gap, input bit spur,
                         input bit mid_req, input int abort_at);
        logic [7:0] exp [NB+2];
        int s0, d0;
        build(snap, exp);
        s0 = starts;
        d0 = dones;
        @(negedge top_clk);
        dump_req = 1'b1;
        snapshot = snap;
        @(negedge top_clk);
        dump_req = 1'b0;
        for (int b = 0; b < NB + 2; b++) begin
            check($sformatf("start%0d", b), tx_start, 1);
            check($sformatf("byte%0d", b), tx_bus, exp[b]);
            check($sformatf("busy%0d", b), busy, 1);
            tx_done_tick = spur;
            if (mid_req && b == 2) begin
                dump_req = 1'b1;
                snapshot = ~snap;
            end
            if (b == abort_at) begin
                @(negedge top_clk);
                tx_done_tick = 1'b0;
                dump_req = 1'b0;
                rst = 1'b0;
                @(negedge top_clk);
                rst = 1'b1;
                check("rst_start", tx_start, 0);
                check("rst_busy", busy, 0);
                check("rst_bus", tx_bus, 0);
                check("rst_done", done, 0);
                s0 = starts;
                repeat (10) @(negedge top_clk);
                check("rst_nostart", starts - s0, 0);
                return;
            end
            repeat (gap) begin
                @(negedge top_clk);
                tx_done_tick = 1'b0;
                dump_req = 1'b0;
                check("hold_start", tx_start, 0);
                check("hold_bus", tx_bus, exp[b]);
            end
            @(negedge top_clk);
            dump_req = 1'b0;
            tx_done_tick = 1'b1;
            check("tick_start", tx_start, 0);
            check("tick_bus", tx_bus, exp[b]);
            @(negedge top_clk);
            tx_done_tick = 1'b0;
            if (b == NB + 1) begin
                check("done", done, 1);
                check("busy_fin", busy, 0);
                @(negedge top_clk);
                check("done_once", done, 0);
            end else begin
                check("prep_start", tx_start, 0);
                check("prep_done", done, 0);
                check("prep_busy", busy, 1);
                @(negedge top_clk);
            end
        end
        repeat (5) @(negedge top_clk);
        check("n_starts", starts - s0, NB + 2);
        check("n_dones", dones - d0, 1);
        check("idle_busy", busy, 0);
    endtask

    initial begin
        repeat (2) @(negedge top_clk);
        check("reset_start", tx_start, 0);
        check("reset_bus", tx_bus, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        rst = 1'b1;
        @(negedge top_clk);
        tx_done_tick = 1'b1;
        @(negedge top_clk);
        tx_done_tick = 1'b0;
        @(negedge top_clk);
        check("idle_tick_start", tx_start, 0);
        check("idle_tick_busy", busy, 0);
        check("idle_tick_cnt", starts, 0);
        frame(32'h11223344, 9, 1'b0, 1'b0, -1);
        frame(32'h00000000, 2, 1'b0, 1'b0, -1);
        frame(32'hFFFFFFFF, 2, 1'b0, 1'b0, -1);
        frame(32'hDEADBEEF, 3, 1'b0, 1'b1, -1);
        frame(32'hCAFEF00D, 4, 1'b0, 1'b0, 3);
        frame(32'h0BADC0DE, 2, 1'b1, 1'b0, -1);
        frame(32'h13579BDF, 0, 1'b0, 1'b0, -1);
        frame(32'h2468ACE0, 0, 1'b1, 1'b1, -1);
        for (int i = 0; i < 10; i++)
            frame($urandom, $urandom_range(0, 4), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), -1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
